fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_pkg.sv | 22 ++
 rtl/pc_register.sv | 19 +
 rtl/fetch_unit.sv | 106 ++++++++++
 tb/tb_fetch_unit.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared fetch-stage types, defaults and address helpers
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FAULT = 2'd2
  } fetch_state_t;

  localparam logic [31:0] DEFAULT_RESET_PC  = 32'h0000_0000;
  localparam int unsigned DEFAULT_MEM_WORDS = 8;
  localparam logic [31:0] ARM_PC_OFFSET     = 32'd8;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'd3;
  endfunction

  function automatic logic addr_in_range(input logic [31:0] addr, input int unsigned words);
    return (addr >> 2) < 32'(words);
  endfunction

endpackage

// File: rtl/pc_register.sv
// rtl/pc_register.sv - program counter register with load enable
module pc_register #(
  parameter logic [31:0] RESET_VALUE = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        load,
  input  logic [31:0] value,
  output logic [31:0] pc
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      pc <= RESET_VALUE;
    else if (load)
      pc <= value;
  end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage with valid/ready handoff, branch redirect and range fault
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter int unsigned MEM_WORDS = DEFAULT_MEM_WORDS
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [31:0] InstrAddress,
  input  logic [31:0] InstrData,
  output logic [31:0] Instr,
  output logic [31:0] PCOut,
  output logic [31:0] PCPlus8,
  output logic        InstrValid,
  input  logic        InstrReady,
  input  logic        BranchTaken,
  input  logic [31:0] BranchTarget,
  output logic        FetchFault,
  output logic [31:0] FetchCount
);

  fetch_state_t state, state_n;
  logic [31:0]  pc, pc_next, target;
  logic         pc_load, fetch, valid_n, fault_n;
  logic         transfer, slot_free, pc_ok, target_ok;

  pc_register #(.RESET_VALUE(word_align(RESET_PC))) u_pc (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (pc_load),
    .value   (pc_next),
    .pc      (pc)
  );

  assign transfer     = InstrValid && InstrReady;
  assign slot_free    = !InstrValid || InstrReady;
  assign target       = word_align(BranchTarget);
  assign pc_ok        = addr_in_range(pc, MEM_WORDS);
  assign target_ok    = addr_in_range(target, MEM_WORDS);
  assign InstrAddress = {2'b00, pc[31:2]};
  assign PCPlus8      = PCOut + ARM_PC_OFFSET;

  always_comb begin
    state_n = state;
    valid_n = InstrValid;
    fault_n = FetchFault;
    fetch   = 1'b0;
    pc_load = 1'b0;
    pc_next = pc + 32'd4;
    // A redirect flushes the output slot in every state; only an in-range target clears a fault.
    if (BranchTaken) begin
      pc_load = 1'b1;
      pc_next = target;
      valid_n = 1'b0;
      if (state == ST_FAULT && !target_ok) begin
        state_n = ST_FAULT;
        fault_n = 1'b1;
      end else begin
        state_n = ST_RUN;
        fault_n = 1'b0;
      end
    end else begin
      unique case (state)
        ST_BOOT: state_n = ST_RUN;
        ST_RUN: begin
          if (slot_free) begin
            if (pc_ok) begin
              fetch   = 1'b1;
              pc_load = 1'b1;
              valid_n = 1'b1;
            end else begin
              state_n = ST_FAULT;
              fault_n = 1'b1;
              valid_n = 1'b0;
            end
          end
        end
        ST_FAULT: if (transfer) valid_n = 1'b0;
        default:  state_n = ST_BOOT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_BOOT;
      Instr      <= 32'd0;
      PCOut      <= 32'd0;
      InstrValid <= 1'b0;
      FetchFault <= 1'b0;
      FetchCount <= 32'd0;
    end else begin
      state      <= state_n;
      InstrValid <= valid_n;
      FetchFault <= fault_n;
      if (fetch) begin
        Instr <= InstrData;
        PCOut <= pc;
      end
      if (transfer && FetchCount != 32'hFFFF_FFFF)
        FetchCount <= FetchCount + 32'd1;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - randomized self-checking bench for fetch_unit against a transaction-level model
module tb_fetch_unit;

  localparam int unsigned MW = 8;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] InstrAddress, InstrData, Instr, PCOut, PCPlus8, FetchCount, BranchTarget;
  logic        InstrValid, InstrReady, BranchTaken, FetchFault;

  logic [31:0] mem [MW];

  always #5 clk = ~clk;

  assign InstrData = (InstrAddress < MW) ? mem[InstrAddress[2:0]] : 32'hDEAD_BEEF;

  fetch_unit #(.RESET_PC(32'h0000_0000), .MEM_WORDS(MW)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .InstrAddress (InstrAddress),
    .InstrData    (InstrData),
    .Instr        (Instr),
    .PCOut        (PCOut),
    .PCPlus8      (PCPlus8),
    .InstrValid   (InstrValid),
    .InstrReady   (InstrReady),
    .BranchTaken  (BranchTaken),
    .BranchTarget (BranchTarget),
    .FetchFault   (FetchFault),
    .FetchCount   (FetchCount)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: what decode should see, tracked as plain variables
  bit          m_boot, m_fault, m_valid;
  logic [31:0] m_pc, m_instr, m_pcout, m_count;

  task automatic model_reset();
    m_boot = 1; m_fault = 0; m_valid = 0;
    m_pc = 32'h0; m_instr = 0; m_pcout = 0; m_count = 0;
  endtask

  task automatic model_step(input bit rdy, input bit br, input logic [31:0] tgt);
    logic [31:0] idx;
    bit xfer;
    xfer = m_valid && rdy;
    if (xfer && m_count != 32'hFFFF_FFFF) m_count = m_count + 1;
    if (br) begin
      m_pc    = {tgt[31:2], 2'b00};
      m_valid = 0;
      m_boot  = 0;
      m_fault = m_fault && ((m_pc / 4) >= MW);
    end else if (m_boot) begin
      m_boot = 0;
    end else if (!m_fault) begin
      if (!m_valid || rdy) begin
        idx = m_pc / 4;
        if (idx < MW) begin
          m_instr = mem[idx[2:0]];
          m_pcout = m_pc;
          m_valid = 1;
          m_pc    = m_pc + 4;
        end else begin
          m_fault = 1;
          m_valid = 0;
        end
      end
    end else if (xfer) begin
      m_valid = 0;
    end
  endtask

  task automatic check_all(input string tag);
    check_eq({tag, ".valid"}, 32'(InstrValid), 32'(m_valid));
    check_eq({tag, ".fault"}, 32'(FetchFault), 32'(m_fault));
    check_eq({tag, ".count"}, FetchCount, m_count);
    check_eq({tag, ".addr"},  InstrAddress, m_pc / 4);
    check_eq({tag, ".instr"}, Instr, m_instr);
    check_eq({tag, ".pcout"}, PCOut, m_pcout);
    check_eq({tag, ".pc8"},   PCPlus8, m_pcout + 8);
  endtask

  // Called at a negedge: drive, check, clock, advance the model, return at the next negedge
  task automatic cycle(input bit rdy, input bit br, input logic [31:0] tgt);
    InstrReady = rdy; BranchTaken = br; BranchTarget = tgt;
    #1 check_all("cyc");
    @(posedge clk);
    model_step(rdy, br, tgt);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n = 0; InstrReady = 0; BranchTaken = 0; BranchTarget = 0;
    #1 model_reset();
    check_all("rst");
    @(negedge clk);
    reset_n = 1;
  endtask

  initial begin
    for (int i = 0; i < MW; i++) mem[i] = $urandom;

    // Reset state and in-order delivery at one per cycle
    do_reset();
    check_eq("boot.valid", 32'(InstrValid), 32'd0);
    cycle(1, 0, 0);
    check_eq("boot1.valid", 32'(InstrValid), 32'd0);
    cycle(1, 0, 0);
    check_eq("w0.instr", Instr, mem[0]);
    check_eq("w0.pc8", PCPlus8, 32'd8);
    cycle(1, 0, 0);
    check_eq("w1.pcout", PCOut, 32'd4);
    cycle(1, 0, 0);
    check_eq("w2.instr", Instr, mem[2]);
    cycle(1, 0, 0);
    check_eq("w3.pc8", PCPlus8, 32'd20);

    // Backpressure holds W1 and its successor address
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 0);
      check_eq("hold.instr", Instr, mem[1]);
      check_eq("hold.addr", InstrAddress, 32'd2);
    end
    check_eq("hold.count", FetchCount, 32'd1);
    cycle(1, 0, 0);
    check_eq("rel.instr", Instr, mem[2]);
    check_eq("rel.count", FetchCount, 32'd2);

    // Branch to an unaligned target coinciding with a transfer
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1, 0, 0);
    cycle(1, 1, 32'h0000_0013);
    check_eq("br.valid", 32'(InstrValid), 32'd0);
    check_eq("br.addr", InstrAddress, 32'd4);
    check_eq("br.count", FetchCount, 32'd2);
    cycle(1, 0, 0);
    check_eq("br.instr", Instr, mem[4]);
    check_eq("br.pcout", PCOut, 32'd16);

    // Run past the last word, then recover with a branch to 0
    do_reset();
    for (int i = 0; i < 9; i++) cycle(1, 0, 0);
    check_eq("end.instr", Instr, mem[7]);
    cycle(1, 0, 0);
    check_eq("flt.fault", 32'(FetchFault), 32'd1);
    check_eq("flt.valid", 32'(InstrValid), 32'd0);
    cycle(1, 0, 0);
    cycle(1, 1, 32'h0);
    check_eq("rec.fault", 32'(FetchFault), 32'd0);
    cycle(1, 0, 0);
    check_eq("rec.instr", Instr, mem[0]);

    // Asynchronous reset pulse between edges while an instruction is valid
    cycle(0, 0, 0);
    InstrReady = 0; BranchTaken = 0;
    #2 reset_n = 0;
    #1 check_eq("arst.valid", 32'(InstrValid), 32'd0);
    check_eq("arst.count", FetchCount, 32'd0);
    check_eq("arst.fault", 32'(FetchFault), 32'd0);
    model_reset();
    #1 reset_n = 1;
    @(posedge clk);
    model_step(0, 0, 0);
    @(negedge clk);
    check_eq("arst.boot", 32'(InstrValid), 32'd0);
    cycle(1, 0, 0);
    check_eq("arst.w0", Instr, mem[0]);

    // Random traffic with redirects in and out of range
    for (int i = 0; i < 400; i++) begin
      logic [31:0] tgt;
      tgt = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, (MW + 2) * 4 - 1));
      cycle(1'($urandom), $urandom_range(0, 9) == 0, tgt);
    end
    cycle(1, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
